// File: rtl/sensor_scan_sequencer.sv
// Sensor scan sequencer: walks the enabled channels of an 8-way analog mux,
// settles each one, averages 2^AvgShift ADC conversions and publishes the
// averaged reading per channel together with a per-channel valid flag.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for ScanEn with a non-zero channel mask
// SELECT | point the mux at the next enabled channel, clear the averager
// SETTLE | hold the mux for SETTLE_CYCLES cycles before converting
// REQ    | conversion handshake; one low cycle of AdcReq between samples
// STORE  | write the averaged reading, then advance, finish or abort
module sensor_scan_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int DATA_W        = 16
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic                   ScanEn,
    input  logic [7:0]             ChanMask,
    input  logic [1:0]             AvgShift,
    output logic [2:0]             AdcChan,
    output logic                   AdcReq,
    input  logic                   AdcAck,
    input  logic [DATA_W-1:0]      AdcData,
    output logic [7:0][DATA_W-1:0] SensorReadings,
    output logic [7:0]             ValidMask,
    output logic                   ScanDone
);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SETTLE,
        REQ,
        STORE
    } state_t;

    state_t state_q, state_d;

    logic [7:0]             mask_q;
    logic [1:0]             shift_q;
    logic [2:0]             cur_chan_q;
    logic [2:0]             chan_q;
    logic                   req_q;
    logic [DATA_W+2:0]      acc_q;
    logic [3:0]             sample_cnt_q;
    logic [3:0]             settle_cnt_q;
    logic [7:0][DATA_W-1:0] readings_q;
    logic [7:0]             valid_q;
    logic                   done_q;

    logic [7:0] ge_mask;
    logic [7:0] higher_mask;
    logic [2:0] sel_chan;
    logic [3:0] sample_next;
    logic [3:0] sample_target;
    logic       ack_ok;

    logic start_scan;
    logic do_select;
    logic settle_dec;
    logic req_set;
    logic sample_take;
    logic do_store;
    logic advance;
    logic done_set;

    // Channel search helpers: lowest enabled channel at or above the
    // current one, and whether anything enabled remains above AdcChan.
    always_comb begin
        ge_mask     = mask_q & (8'hFF << cur_chan_q);
        higher_mask = mask_q & (8'hFE << chan_q);
        sel_chan    = cur_chan_q;
        for (int i = 7; i >= 0; i--) begin
            if (ge_mask[i]) begin
                sel_chan = 3'(i);
            end
        end
        sample_next   = sample_cnt_q + 4'd1;
        sample_target = 4'd1 << shift_q;
        ack_ok        = req_q & AdcAck;
    end

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_d     = state_q;
        start_scan  = 1'b0;
        do_select   = 1'b0;
        settle_dec  = 1'b0;
        req_set     = 1'b0;
        sample_take = 1'b0;
        do_store    = 1'b0;
        advance     = 1'b0;
        done_set    = 1'b0;
        case (state_q)
            IDLE: begin
                if (ScanEn && (ChanMask != 8'h00)) begin
                    start_scan = 1'b1;
                    state_d    = SELECT;
                end
            end
            SELECT: begin
                do_select = 1'b1;
                state_d   = SETTLE;
            end
            SETTLE: begin
                if (settle_cnt_q == 4'd0) begin
                    req_set = 1'b1;
                    state_d = REQ;
                end else begin
                    settle_dec = 1'b1;
                end
            end
            REQ: begin
                if (req_q) begin
                    if (ack_ok) begin
                        sample_take = 1'b1;
                        if (sample_next == sample_target) begin
                            state_d = STORE;
                        end
                    end
                end else begin
                    // Single idle cycle between back-to-back conversions.
                    req_set = 1'b1;
                end
            end
            STORE: begin
                do_store = 1'b1;
                if (higher_mask == 8'h00) begin
                    done_set = 1'b1;
                    state_d  = IDLE;
                end else if (!ScanEn) begin
                    state_d = IDLE;
                end else begin
                    advance = 1'b1;
                    state_d = SELECT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan-local configuration, mux select, averager, settle timer and outputs.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            mask_q       <= '0;
            shift_q      <= '0;
            cur_chan_q   <= '0;
            chan_q       <= '0;
            req_q        <= 1'b0;
            acc_q        <= '0;
            sample_cnt_q <= '0;
            settle_cnt_q <= '0;
            readings_q   <= '0;
            valid_q      <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= done_set;
            if (start_scan) begin
                mask_q     <= ChanMask;
                shift_q    <= AvgShift;
                cur_chan_q <= 3'd0;
            end
            if (do_select) begin
                chan_q       <= sel_chan;
                acc_q        <= '0;
                sample_cnt_q <= '0;
                settle_cnt_q <= 4'(SETTLE_CYCLES - 1);
            end
            if (settle_dec) begin
                settle_cnt_q <= settle_cnt_q - 4'd1;
            end
            if (req_set) begin
                req_q <= 1'b1;
            end else if (sample_take) begin
                req_q <= 1'b0;
            end
            if (sample_take) begin
                acc_q        <= acc_q + {3'b000, AdcData};
                sample_cnt_q <= sample_next;
            end
            if (do_store) begin
                readings_q[chan_q] <= DATA_W'(acc_q >> shift_q);
                valid_q[chan_q]    <= 1'b1;
            end
            if (advance) begin
                cur_chan_q <= chan_q + 3'd1;
            end
        end
    end

    assign AdcChan        = chan_q;
    assign AdcReq         = req_q;
    assign SensorReadings = readings_q;
    assign ValidMask      = valid_q;
    assign ScanDone       = done_q;

endmodule

// File: tb/tb_sensor_scan_sequencer.sv
// Bench for sensor_scan_sequencer: a behavioural ADC answers every request
// after a programmable delay and logs each accepted sample; a scan-level
// reference model turns the logged samples into expected readings.
module tb_sensor_scan_sequencer;

    localparam int SETTLE = 4;
    localparam int DW     = 16;

    logic              PCLK;
    logic              PRESETn;
    logic              ScanEn;
    logic [7:0]        ChanMask;
    logic [1:0]        AvgShift;
    logic [2:0]        AdcChan;
    logic              AdcReq;
    logic              AdcAck;
    logic [DW-1:0]     AdcData;
    logic [7:0][DW-1:0] SensorReadings;
    logic [7:0]        ValidMask;
    logic              ScanDone;

    sensor_scan_sequencer #(
        .SETTLE_CYCLES(SETTLE),
        .DATA_W       (DW)
    ) dut (
        .PCLK          (PCLK),
        .PRESETn       (PRESETn),
        .ScanEn        (ScanEn),
        .ChanMask      (ChanMask),
        .AvgShift      (AvgShift),
        .AdcChan       (AdcChan),
        .AdcReq        (AdcReq),
        .AdcAck        (AdcAck),
        .AdcData       (AdcData),
        .SensorReadings(SensorReadings),
        .ValidMask     (ValidMask),
        .ScanDone      (ScanDone)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;

    // ADC model controls (written only by the main sequence)
    int            ack_delay  = 3;
    bit            fixed_mode = 0;
    int            fixed_base = 0;
    logic [DW-1:0] fixed_data [8];
    int            stale_req  = 0;

    // ADC model state (written only by the responder)
    int            stale_done = 0;
    int            age        = 0;
    logic [2:0]    log_chan [$];
    logic [DW-1:0] log_data [$];

    // Reference model of published outputs
    int         exp_read [8];
    logic [7:0] exp_valid;

    // Behavioural ADC: acks ack_delay cycles after AdcReq rises.
    initial begin
        logic [DW-1:0] d;
        AdcAck  = 1'b0;
        AdcData = '0;
        forever begin
            @(posedge PCLK);
            #1;
            AdcAck = 1'b0;
            if (stale_req != stale_done) begin
                stale_done = stale_req;
                AdcAck     = 1'b1;
                AdcData    = 16'hDEAD;
            end else if (AdcReq) begin
                if (age >= ack_delay) begin
                    if (fixed_mode) d = fixed_data[(log_data.size() - fixed_base) % 8];
                    else d = DW'($urandom);
                    AdcAck  = 1'b1;
                    AdcData = d;
                    log_chan.push_back(AdcChan);
                    log_data.push_back(d);
                    age = 0;
                end else begin
                    age++;
                end
            end else begin
                age = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        for (int ch = 0; ch < 8; ch++)
            chk($sformatf("reading%0d", ch), 64'(SensorReadings[ch]), 64'(exp_read[ch]));
        chk("valid_mask", 64'(ValidMask), 64'(exp_valid));
    endtask

    // Expected result of a scan over the channels of mask up to last_ch,
    // built from the samples the ADC model actually delivered.
    task automatic model_scan(input int base, input logic [7:0] mask, input int shift, input int last_ch);
        int order [$];
        int sums [8];
        int n;
        int got;
        n = 1 << shift;
        for (int ch = 0; ch < 8; ch++) begin
            sums[ch] = 0;
            if (mask[ch] && ch <= last_ch)
                for (int s = 0; s < n; s++) order.push_back(ch);
        end
        got = log_chan.size() - base;
        chk("sample_count", 64'(got), 64'(order.size()));
        if (got == order.size()) begin
            for (int i = 0; i < order.size(); i++) begin
                chk("chan_order", 64'(log_chan[base + i]), 64'(order[i]));
                sums[order[i]] += int'(log_data[base + i]);
            end
            for (int ch = 0; ch < 8; ch++) begin
                if (mask[ch] && ch <= last_ch) begin
                    exp_read[ch]  = (sums[ch] >> shift) & 32'hFFFF;
                    exp_valid[ch] = 1'b1;
                end
            end
        end
        compare_all();
    endtask

    task automatic wait_done(input int budget, output bit seen, output int cycles);
        seen   = 0;
        cycles = 0;
        while (!seen && cycles < budget) begin
            @(posedge PCLK);
            #1;
            cycles++;
            if (ScanDone) seen = 1;
        end
    endtask

    task automatic do_scan(input logic [7:0] mask, input int shift, input int delay);
        int base;
        bit seen;
        int cyc;
        ChanMask  = mask;
        AvgShift  = 2'(shift);
        ack_delay = delay;
        base      = log_chan.size();
        ScanEn    = 1'b1;
        wait_done(4000, seen, cyc);
        chk("scan_done_seen", 64'(seen), 64'd1);
        ScanEn = 1'b0;
        @(posedge PCLK);
        #1;
        chk("scan_done_width", 64'(ScanDone), 64'd0);
        model_scan(base, mask, shift, 7);
    endtask

    initial begin
        int  n;
        int  m;
        int  base;
        int  base2;
        int  sh;
        int  pulses;
        bit  seen;
        logic [7:0] rmask;

        for (int ch = 0; ch < 8; ch++) exp_read[ch] = 0;
        exp_valid = '0;
        PRESETn  = 1'b1;
        ScanEn   = 1'b0;
        ChanMask = '0;
        AvgShift = '0;
        #2 PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_req", 64'(AdcReq), 64'd0);
        chk("rst_chan", 64'(AdcChan), 64'd0);
        chk("rst_done", 64'(ScanDone), 64'd0);
        compare_all();
        #2 PRESETn = 1'b1;

        // Empty mask: no conversion requests, no scan completion
        @(posedge PCLK);
        #1;
        ScanEn = 1'b1;
        n = 0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge PCLK);
            #1;
            if (AdcReq) n++;
            if (ScanDone) pulses++;
        end
        chk("zero_mask_reqs", 64'(n), 64'd0);
        chk("zero_mask_done", 64'(pulses), 64'd0);
        ScanEn = 1'b0;
        @(posedge PCLK);
        #1;

        // Single channel, single sample, fixed 3-cycle ADC latency
        for (int i = 0; i < 8; i++) fixed_data[i] = 16'h1234;
        fixed_mode = 1;
        fixed_base = log_data.size();
        ack_delay  = 3;
        base       = log_chan.size();
        ChanMask   = 8'h01;
        AvgShift   = 2'd0;
        ScanEn     = 1'b1;
        n = 0;
        while (!AdcReq && n < 60) begin
            @(posedge PCLK);
            #1;
            n++;
        end
        // accept edge (IDLE->SELECT), SELECT, then SETTLE cycles
        chk("req_latency", 64'(n), 64'(1 + 1 + SETTLE));
        m = 0;
        while (!ValidMask[0] && m < 60) begin
            @(posedge PCLK);
            #1;
            m++;
        end
        // REQ spans ack_delay+1 cycles, then one STORE cycle
        chk("store_latency", 64'(m), 64'(3 + 1 + 1));
        chk("done_with_store", 64'(ScanDone), 64'd1);
        ScanEn = 1'b0;
        @(posedge PCLK);
        #1;
        chk("done_pulse_end", 64'(ScanDone), 64'd0);
        model_scan(base, 8'h01, 0, 7);
        chk("reading0_const", 64'(SensorReadings[0]), 64'h1234);

        // Sparse mask 0xA5 with random data
        fixed_mode = 0;
        do_scan(8'hA5, 0, 2);

        // Full-scale average of eight samples
        for (int i = 0; i < 8; i++) fixed_data[i] = 16'hFFFF;
        fixed_mode = 1;
        fixed_base = log_data.size();
        do_scan(8'h08, 3, 1);
        chk("fullscale_avg", 64'(SensorReadings[3]), 64'hFFFF);
        for (int i = 0; i < 8; i++) fixed_data[i] = 16'(i + 1);
        fixed_base = log_data.size();
        do_scan(8'h08, 3, 2);
        chk("ramp_avg", 64'(SensorReadings[3]), 64'h0004);
        fixed_mode = 0;

        // Random masks, averaging depths and ADC latencies
        repeat (5) begin
            rmask = 8'($urandom_range(1, 255));
            do_scan(rmask, int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
        end

        // ScanEn withdrawn while channel 2 settles
        sh        = int'($urandom_range(0, 1));
        ChanMask  = 8'hFF;
        AvgShift  = 2'(sh);
        ack_delay = 2;
        base      = log_chan.size();
        ScanEn    = 1'b1;
        n = 0;
        while (!(AdcReq && AdcChan == 3'd0) && n < 200) begin
            @(posedge PCLK);
            #1;
            n++;
        end
        while (!(AdcChan == 3'd2 && !AdcReq) && n < 400) begin
            @(posedge PCLK);
            #1;
            n++;
        end
        chk("reach_ch2_settle", 64'(n < 400), 64'd1);
        ScanEn = 1'b0;
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge PCLK);
            #1;
            if (ScanDone) pulses++;
        end
        chk("abort_no_done", 64'(pulses), 64'd0);
        chk("abort_idle_req", 64'(AdcReq), 64'd0);
        model_scan(base, 8'hFF, sh, 2);

        // Mask change mid-scan only takes effect at the next scan start
        ChanMask  = 8'h01;
        AvgShift  = 2'd0;
        ack_delay = 2;
        base      = log_chan.size();
        ScanEn    = 1'b1;
        n = 0;
        while (!AdcReq && n < 60) begin
            @(posedge PCLK);
            #1;
            n++;
        end
        ChanMask = 8'h02;
        wait_done(200, seen, n);
        chk("scan_a_done", 64'(seen), 64'd1);
        model_scan(base, 8'h01, 0, 7);
        base2 = log_chan.size();
        wait_done(200, seen, n);
        chk("scan_b_done", 64'(seen), 64'd1);
        // IDLE + SELECT + SETTLE + REQ(delay+1) + STORE between pulses
        chk("back_to_back", 64'(n), 64'(1 + 1 + SETTLE + 2 + 1 + 1));
        ScanEn = 1'b0;
        @(posedge PCLK);
        #1;
        chk("scan_b_pulse_end", 64'(ScanDone), 64'd0);
        model_scan(base2, 8'h02, 0, 7);

        // Reset during an outstanding request, stale ack after release
        ChanMask  = 8'h01;
        AvgShift  = 2'd1;
        ack_delay = 2;
        ScanEn    = 1'b1;
        n = 0;
        while (!AdcReq && n < 60) begin
            @(posedge PCLK);
            #1;
            n++;
        end
        chk("pre_reset_req", 64'(AdcReq), 64'd1);
        PRESETn = 1'b0;
        #1;
        chk("async_req_drop", 64'(AdcReq), 64'd0);
        chk("async_chan", 64'(AdcChan), 64'd0);
        chk("async_done", 64'(ScanDone), 64'd0);
        for (int ch = 0; ch < 8; ch++) exp_read[ch] = 0;
        exp_valid = '0;
        compare_all();
        repeat (2) @(posedge PCLK);
        base = log_chan.size();
        @(posedge PCLK);
        #3;
        PRESETn = 1'b1;
        stale_req++;
        wait_done(400, seen, n);
        chk("post_reset_done", 64'(seen), 64'd1);
        ScanEn = 1'b0;
        model_scan(base, 8'h01, 1, 7);

        repeat (3) @(posedge PCLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
